// File: rtl/ingress_frame_buffer_if.sv
// ingress_frame_buffer_if: per-port rx lanes, drop pulses and the merged output byte stream
interface ingress_frame_buffer_if #(parameter int N_PORTS = 4);
  localparam int PW = $clog2(N_PORTS);
  logic [N_PORTS-1:0] link_sync;
  logic [8*N_PORTS-1:0] rx_data;
  logic [N_PORTS-1:0] rx_ctrl;
  logic [7:0] out_data;
  logic out_valid;
  logic out_ready;
  logic out_sof;
  logic out_eof;
  logic [PW-1:0] out_port;
  logic [N_PORTS-1:0] drop_pulse;
  modport master (
    output link_sync, rx_data, rx_ctrl, out_ready,
    input out_data, out_valid, out_sof, out_eof, out_port, drop_pulse
  );
  modport slave (
    input link_sync, rx_data, rx_ctrl, out_ready,
    output out_data, out_valid, out_sof, out_eof, out_port, drop_pulse
  );
endinterface

// File: rtl/ingress_frame_buffer.sv
// ingress_frame_buffer: per-port store-and-forward FIFOs with commit/rollback, round-robin drain
module ingress_frame_buffer #(
  parameter int N_PORTS = 4,
  parameter int P_ADDR_WIDTH = 7,
  parameter int MIN_FRAME_BYTES = 64
) (
  input logic clk,
  input logic reset,
  ingress_frame_buffer_if.slave bus
);
  localparam int AW = P_ADDR_WIDTH;
  localparam int DEPTH = 2**AW;
  localparam int PW = $clog2(N_PORTS);
  typedef logic [AW:0] ptr_t;
  typedef enum logic [1:0] {IDLE, RECV, DROP} rx_state_t;
  typedef enum logic {O_IDLE, O_SEND} out_state_t;
  localparam ptr_t FULL = {1'b1, {AW{1'b0}}};
  logic [N_PORTS-1:0] has_frame;
  logic [N_PORTS-1:0] rd_inc;
  logic [8:0] head [N_PORTS];
  logic [8:0] cur;
  out_state_t ostate;
  logic [PW-1:0] last_grant, pick, idx;
  logic found;
  for (genvar p = 0; p < N_PORTS; p++) begin : g_port
    rx_state_t state;
    logic [7:0] hold;
    logic [15:0] len;
    ptr_t spec_ptr, commit_ptr, rd_ptr, frame_cnt;
    logic [8:0] mem [DEPTH];
    logic ctrl, sync, full, wr, commit, pulse;
    assign ctrl = bus.rx_ctrl[p];
    assign sync = bus.link_sync[p];
    assign full = spec_ptr - rd_ptr == FULL;
    assign wr = reset && state == RECV && sync && !full;
    assign commit = wr && !ctrl && len >= 16'(MIN_FRAME_BYTES);
    assign head[p] = mem[rd_ptr[AW-1:0]];
    assign has_frame[p] = |frame_cnt;
    assign bus.drop_pulse[p] = pulse;
    // the held byte is written one cycle late so its last flag is known
    always_ff @(posedge clk)
      if (wr) mem[spec_ptr[AW-1:0]] <= {~ctrl, hold};
    always_ff @(posedge clk)
      if (!reset) begin
        state <= IDLE;
        hold <= '0;
        len <= '0;
        spec_ptr <= '0;
        commit_ptr <= '0;
        pulse <= 1'b0;
      end else begin
        pulse <= 1'b0;
        case (state)
          IDLE: if (ctrl) begin
            state <= sync ? RECV : DROP;
            hold <= bus.rx_data[8*p +: 8];
            len <= 16'd1;
            spec_ptr <= commit_ptr;
          end
          RECV: if (!sync || full) begin
            spec_ptr <= commit_ptr;
            pulse <= 1'b1;
            state <= (sync && !ctrl) ? IDLE : DROP;
          end else if (ctrl) begin
            spec_ptr <= spec_ptr + ptr_t'(1);
            hold <= bus.rx_data[8*p +: 8];
            len <= len + 16'(~&len);
          end else begin
            state <= IDLE;
            spec_ptr <= commit ? spec_ptr + ptr_t'(1) : commit_ptr;
            commit_ptr <= commit ? spec_ptr + ptr_t'(1) : commit_ptr;
            pulse <= !commit;
          end
          default: if (!ctrl) state <= IDLE;
        endcase
      end
    always_ff @(posedge clk)
      if (!reset) begin
        rd_ptr <= '0;
        frame_cnt <= '0;
      end else begin
        rd_ptr <= rd_ptr + ptr_t'(rd_inc[p]);
        frame_cnt <= frame_cnt + ptr_t'(commit) - ptr_t'(rd_inc[p] & head[p][8]);
      end
  end
  always_comb begin
    pick = last_grant;
    found = 1'b0;
    idx = '0;
    for (int i = 1; i <= N_PORTS; i++) begin
      idx = PW'((int'(last_grant) + i) % N_PORTS);
      if (!found && has_frame[idx]) begin
        found = 1'b1;
        pick = idx;
      end
    end
  end
  assign cur = head[bus.out_port];
  assign bus.out_data = bus.out_valid ? cur[7:0] : '0;
  assign bus.out_eof = bus.out_valid & cur[8];
  always_comb begin
    rd_inc = '0;
    rd_inc[bus.out_port] = bus.out_valid & bus.out_ready;
  end
  always_ff @(posedge clk)
    if (!reset) begin
      ostate <= O_IDLE;
      last_grant <= PW'(N_PORTS - 1);
      bus.out_port <= '0;
      bus.out_valid <= 1'b0;
      bus.out_sof <= 1'b0;
    end else if (ostate == O_IDLE) begin
      if (found) begin
        ostate <= O_SEND;
        last_grant <= pick;
        bus.out_port <= pick;
        bus.out_valid <= 1'b1;
        bus.out_sof <= 1'b1;
      end
    end else if (bus.out_ready) begin
      bus.out_sof <= 1'b0;
      if (cur[8]) begin
        ostate <= O_IDLE;
        bus.out_valid <= 1'b0;
      end
    end
endmodule

// File: tb/tb_ingress_frame_buffer.sv
// tb_ingress_frame_buffer: table-driven frames with an output scoreboard plus reset/latency sequences
module tb_ingress_frame_buffer;
  logic clk = 1'b0;
  logic reset = 1'b0;
  ingress_frame_buffer_if #(.N_PORTS(4)) bus ();
  ingress_frame_buffer #(.N_PORTS(4), .P_ADDR_WIDTH(7), .MIN_FRAME_BYTES(64)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [1:0] port;
    logic sof;
    logic eof;
    logic [7:0] data;
  } exp_t;
  typedef struct {
    logic [3:0] mask;
    int len;
    logic [7:0] base;
    int kill_at;
    logic stall;
    logic [3:0] exp_drop;
  } vec_t;
  exp_t sb [$];
  vec_t tbl [12];
  int n_vec = 0;
  int n_err = 0;
  int drops [4] = '{0, 0, 0, 0};
  int snap [4];
  int rmode = 1;
  logic pv = 1'b0;
  logic [12:0] prev;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [7:0] dbyte(input int p, input int i, input logic [7:0] base);
    return (i == 0) ? 8'(p) : 8'(base + 8'(i) + 8'(p << 6));
  endfunction
  task automatic send(input logic [3:0] mask, input int len, input logic [7:0] base, input int kill_at);
    for (int i = 0; i < len; i++) begin
      @(posedge clk); #1;
      bus.rx_ctrl = mask;
      for (int p = 0; p < 4; p++) bus.rx_data[8*p +: 8] = dbyte(p, i, base);
      if (kill_at > 0 && i >= kill_at) bus.link_sync = ~mask;
    end
    @(posedge clk); #1;
    bus.rx_ctrl = '0;
    bus.link_sync = '1;
  endtask
  task automatic expect_frames(input logic [3:0] ports, input int len, input logic [7:0] base);
    for (int p = 0; p < 4; p++)
      if (ports[p])
        for (int i = 0; i < len; i++) sb.push_back('{2'(p), i == 0, i == len - 1, dbyte(p, i, base)});
  endtask
  task automatic drain(input string name);
    int t = 0;
    while ((sb.size() != 0 || bus.out_valid) && t < 4000) begin
      @(negedge clk);
      t++;
    end
    check({name, " drained"}, sb.size(), 0);
  endtask
  task automatic take_snap();
    for (int p = 0; p < 4; p++) snap[p] = drops[p];
  endtask
  initial forever begin
    @(posedge clk); #1;
    bus.out_ready = (rmode == 2) ? 1'($urandom_range(0, 1)) : (rmode == 1);
  end
  always @(negedge clk) begin
    if (!reset) pv = 1'b0;
    else begin
      for (int p = 0; p < 4; p++) if (bus.drop_pulse[p]) drops[p]++;
      if (pv) check("stall_hold", {bus.out_valid, bus.out_port, bus.out_sof, bus.out_eof, bus.out_data}, prev);
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_byte: got port %0d data %0h, expected no output", bus.out_port, bus.out_data);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("out_byte", {bus.out_port, bus.out_sof, bus.out_eof, bus.out_data}, {e.port, e.sof, e.eof, e.data});
        end
      end
      pv = bus.out_valid && !bus.out_ready;
      prev = {bus.out_valid, bus.out_port, bus.out_sof, bus.out_eof, bus.out_data};
    end
  end
  initial begin
    #800000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
  initial begin
    tbl[0]  = '{4'b0001,  64, 8'h00,  0, 1'b0, 4'b0000};
    tbl[1]  = '{4'b0001,  10, 8'h20,  0, 1'b0, 4'b0001};
    tbl[2]  = '{4'b0010,  63, 8'h30,  0, 1'b0, 4'b0010};
    tbl[3]  = '{4'b0010, 128, 8'h40,  0, 1'b0, 4'b0000};
    tbl[4]  = '{4'b0010, 129, 8'h50,  0, 1'b1, 4'b0010};
    tbl[5]  = '{4'b0010, 200, 8'h60,  0, 1'b1, 4'b0010};
    tbl[6]  = '{4'b0100,  64, 8'h70, 30, 1'b0, 4'b0100};
    tbl[7]  = '{4'b1000, 100, 8'h80,  0, 1'b0, 4'b0000};
    tbl[8]  = '{4'b1111,  64, 8'h00,  0, 1'b0, 4'b0000};
    tbl[9]  = '{4'b1111,  64, 8'h11,  0, 1'b0, 4'b0000};
    tbl[10] = '{4'b1010,  70, 8'h22,  0, 1'b0, 4'b0000};
    tbl[11] = '{4'b0001,   1, 8'h33,  0, 1'b0, 4'b0001};
    bus.rx_ctrl = '0;
    bus.rx_data = '0;
    bus.link_sync = '1;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", bus.out_valid, 0);
    check("rst_data", bus.out_data, 0);
    check("rst_sof_eof", {bus.out_sof, bus.out_eof}, 0);
    check("rst_port", bus.out_port, 0);
    check("rst_drop", bus.drop_pulse, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    send(4'b0001, 64, 8'h00, 0);
    expect_frames(4'b0001, 64, 8'h00);
    @(posedge clk);
    @(negedge clk);
    check("lat_idle_gap", bus.out_valid, 0);
    @(negedge clk);
    check("lat_first", {bus.out_valid, bus.out_sof, bus.out_port, bus.out_data}, {1'b1, 1'b1, 2'd0, 8'h00});
    drain("lat");
    take_snap();
    send(4'b1000, 5, 8'h00, 0);
    @(posedge clk);
    @(negedge clk);
    check("runt_pulse", bus.drop_pulse, 4'b1000);
    @(negedge clk);
    check("runt_pulse_end", bus.drop_pulse, 4'b0000);
    check("runt_count", drops[3] - snap[3], 1);
    for (int pass = 0; pass < 2; pass++)
      for (int k = 0; k < 12; k++) begin
        take_snap();
        rmode = tbl[k].stall ? 0 : pass + 1;
        send(tbl[k].mask, tbl[k].len, tbl[k].base, tbl[k].kill_at);
        expect_frames(tbl[k].mask & ~tbl[k].exp_drop, tbl[k].len, tbl[k].base);
        repeat (3) @(negedge clk);
        for (int p = 0; p < 4; p++) check($sformatf("v%0d_%0d drop%0d", pass, k, p), drops[p] - snap[p], 32'(tbl[k].exp_drop[p]));
        rmode = pass + 1;
        drain($sformatf("v%0d_%0d", pass, k));
      end
    rmode = 2;
    send(4'b0001, 100, 8'h10, 0);
    expect_frames(4'b0001, 100, 8'h10);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      bus.rx_ctrl = 4'b0010;
      bus.rx_data[15:8] = 8'(i);
    end
    take_snap();
    @(posedge clk); #1;
    reset = 1'b0;
    bus.rx_ctrl = '0;
    @(posedge clk); #1;
    sb.delete();
    @(negedge clk);
    check("midrst_outs", {bus.out_valid, bus.out_sof, bus.out_eof, bus.out_port, bus.out_data}, 0);
    check("midrst_drop", bus.drop_pulse, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (100) @(negedge clk);
    for (int p = 0; p < 4; p++) check($sformatf("midrst drop%0d", p), drops[p] - snap[p], 0);
    check("midrst_quiet", bus.out_valid, 0);
    send(4'b0100, 64, 8'h90, 0);
    expect_frames(4'b0100, 64, 8'h90);
    drain("post_rst");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
